// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the 5-stage CPU pipeline control.
//   REG_W       : architectural register index width
//   MDU_LAT_DEF : default number of EX cycles a mul/div occupies
//   N_STAGES    : number of pipeline stages
//   stage_e     : stage indices used to address per-stage valid vectors
package cpu_pipe_pkg;

  localparam int REG_W       = 5;
  localparam int MDU_LAT_DEF = 4;
  localparam int N_STAGES    = 5;

  typedef enum logic [2:0] {
    ST_FE  = 3'd0,
    ST_DE  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } stage_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the pipeline controller and the CPU datapath.
//   Datapath -> controller : DE source regs and usage, EX/MEM/WB writeback
//                            info, dram_busy, exc_flush.
//   Controller -> datapath : per-stage valid bits, PC / stage load enables,
//                            de_stall, ex_busy.
// modport master : the controller side.
// modport slave  : the datapath side.
interface pipeline_ctrl_if;
  import cpu_pipe_pkg::*;

  logic [REG_W-1:0] raddr1;
  logic [REG_W-1:0] raddr2;
  logic             de_uses_rs;
  logic             de_uses_rt;
  logic             de_is_br;
  logic             de_is_mdu;
  logic             ex_wen;
  logic [REG_W-1:0] ex_dest;
  logic             ex_is_load;
  logic             mem_wen;
  logic [REG_W-1:0] mem_dest;
  logic             mem_is_load;
  logic             dram_busy;
  logic             wb_wen;
  logic [REG_W-1:0] wb_dest;
  logic             exc_flush;

  logic             fe_valid;
  logic             de_valid;
  logic             ex_valid;
  logic             mem_valid;
  logic             wb_valid;
  logic             pc_we;
  logic             de_ce;
  logic             ex_ce;
  logic             mem_ce;
  logic             wb_ce;
  logic             de_stall;
  logic             ex_busy;

  modport master (
    input  raddr1, raddr2, de_uses_rs, de_uses_rt, de_is_br, de_is_mdu,
           ex_wen, ex_dest, ex_is_load, mem_wen, mem_dest, mem_is_load,
           dram_busy, wb_wen, wb_dest, exc_flush,
    output fe_valid, de_valid, ex_valid, mem_valid, wb_valid,
           pc_we, de_ce, ex_ce, mem_ce, wb_ce, de_stall, ex_busy
  );

  modport slave (
    output raddr1, raddr2, de_uses_rs, de_uses_rt, de_is_br, de_is_mdu,
           ex_wen, ex_dest, ex_is_load, mem_wen, mem_dest, mem_is_load,
           dram_busy, wb_wen, wb_dest, exc_flush,
    input  fe_valid, de_valid, ex_valid, mem_valid, wb_valid,
           pc_we, de_ce, ex_ce, mem_ce, wb_ce, de_stall, ex_busy
  );

endinterface

// File: rtl/pipe_hazard_unit.sv
// Combinational RAW hazard detector for the decode stage.
// Inputs : DE source regs (raddr1/raddr2) with usage flags and branch flag,
//          EX/MEM/WB valid + writeback enable + destination, load flags of
//          EX and MEM, dram_busy.
// Output : hazard (not yet gated by de_valid).
// FWD_EN=0 stalls on any in-flight writer of a source register. FWD_EN=1
// assumes EX/MEM->DE forwarding, so only values that cannot be forwarded in
// time stall: a load still in EX, any EX result needed by a DE branch, and a
// load in MEM whose data RAM access has not finished.
module pipe_hazard_unit
  import cpu_pipe_pkg::*;
#(
  parameter bit FWD_EN = 1'b0
) (
  input  logic [REG_W-1:0] raddr1,
  input  logic [REG_W-1:0] raddr2,
  input  logic             uses_rs,
  input  logic             uses_rt,
  input  logic             is_br,
  input  logic             ex_valid,
  input  logic             ex_wen,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_is_load,
  input  logic             mem_valid,
  input  logic             mem_wen,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_is_load,
  input  logic             dram_busy,
  input  logic             wb_valid,
  input  logic             wb_wen,
  input  logic [REG_W-1:0] wb_dest,
  output logic             hazard
);

  // $0 is hardwired to zero, so reading it never depends on a producer.
  function automatic logic src_hazard(input logic [REG_W-1:0] src,
                                      input logic             used);
    logic e;
    logic m;
    logic w;
    e = ex_valid  & ex_wen  & (ex_dest  == src);
    m = mem_valid & mem_wen & (mem_dest == src);
    w = wb_valid  & wb_wen  & (wb_dest  == src);
    if (!used || (src == '0)) begin
      return 1'b0;
    end
    if (FWD_EN) begin
      return (e & (ex_is_load | is_br)) | (m & mem_is_load & dram_busy);
    end
    return e | m | w;
  endfunction

  assign hazard = src_hazard(raddr1, uses_rs) | src_hazard(raddr2, uses_rt);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central controller for the FE/DE/EX/MEM/WB pipeline. Owns the per-stage
// valid bits and the allow-in / ready-go chain, and from those drives the PC
// and stage-register load enables. No datapath lives here.
// Ports:
//   clk    : clock
//   resetn : asynchronous active-low reset
//   bus    : pipeline_ctrl_if.master (hazard info in; valids/enables out)
// Parameters:
//   FWD_EN  : 1 = forwarding present, stall only on unforwardable hazards
//   MDU_LAT : EX cycles for a mul/div op (>= 1)
module pipeline_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter bit FWD_EN  = 1'b0,
  parameter int MDU_LAT = MDU_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  pipeline_ctrl_if.master        bus
);

  localparam int              CNT_W    = $clog2(MDU_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

  logic [N_STAGES-1:0] valid;
  logic [CNT_W-1:0]    cnt;

  logic hazard_raw;
  logic hazard;
  logic de_rdy;
  logic ex_rdy;
  logic mem_rdy;
  logic de_allowin;
  logic ex_allowin;
  logic mem_allowin;
  logic fe_to_de;
  logic de_to_ex;
  logic ex_to_mem;
  logic mem_to_wb;
  logic ex_ce;

  pipe_hazard_unit #(
    .FWD_EN (FWD_EN)
  ) u_hazard (
    .raddr1      (bus.raddr1),
    .raddr2      (bus.raddr2),
    .uses_rs     (bus.de_uses_rs),
    .uses_rt     (bus.de_uses_rt),
    .is_br       (bus.de_is_br),
    .ex_valid    (valid[ST_EX]),
    .ex_wen      (bus.ex_wen),
    .ex_dest     (bus.ex_dest),
    .ex_is_load  (bus.ex_is_load),
    .mem_valid   (valid[ST_MEM]),
    .mem_wen     (bus.mem_wen),
    .mem_dest    (bus.mem_dest),
    .mem_is_load (bus.mem_is_load),
    .dram_busy   (bus.dram_busy),
    .wb_valid    (valid[ST_WB]),
    .wb_wen      (bus.wb_wen),
    .wb_dest     (bus.wb_dest),
    .hazard      (hazard_raw)
  );

  // Ready-go: FE and WB are always ready and WB always allows in.
  assign hazard  = valid[ST_DE] & hazard_raw;
  assign de_rdy  = ~hazard;
  assign ex_rdy  = (cnt == '0);
  assign mem_rdy = ~bus.dram_busy;

  // Allow-in chain, evaluated from WB backwards.
  assign mem_allowin = ~valid[ST_MEM] | mem_rdy;
  assign ex_allowin  = ~valid[ST_EX]  | (ex_rdy & mem_allowin);
  assign de_allowin  = ~valid[ST_DE]  | (de_rdy & ex_allowin);

  assign fe_to_de  = valid[ST_FE];
  assign de_to_ex  = valid[ST_DE]  & de_rdy;
  assign ex_to_mem = valid[ST_EX]  & ex_rdy;
  assign mem_to_wb = valid[ST_MEM] & mem_rdy;

  assign ex_ce = ex_allowin & de_to_ex;

  // The flush term keeps PC loading the exception vector even while the
  // pipeline is otherwise stalled.
  assign bus.pc_we    = (valid[ST_FE] & de_allowin) | bus.exc_flush;
  assign bus.de_ce    = de_allowin & fe_to_de;
  assign bus.ex_ce    = ex_ce;
  assign bus.mem_ce   = mem_allowin & ex_to_mem;
  assign bus.wb_ce    = mem_to_wb;
  assign bus.de_stall = hazard;
  assign bus.ex_busy  = valid[ST_EX] & (cnt != '0);

  assign bus.fe_valid  = valid[ST_FE];
  assign bus.de_valid  = valid[ST_DE];
  assign bus.ex_valid  = valid[ST_EX];
  assign bus.mem_valid = valid[ST_MEM];
  assign bus.wb_valid  = valid[ST_WB];

  // Stage valid registers and MDU countdown.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= '0;
      cnt   <= '0;
    end else begin
      valid[ST_FE] <= 1'b1;
      if (bus.exc_flush) begin
        // The WB instruction raising the flush retires now; everything
        // younger is discarded.
        valid[ST_DE]  <= 1'b0;
        valid[ST_EX]  <= 1'b0;
        valid[ST_MEM] <= 1'b0;
        valid[ST_WB]  <= 1'b0;
        cnt           <= '0;
      end else begin
        if (de_allowin)  valid[ST_DE]  <= fe_to_de;
        if (ex_allowin)  valid[ST_EX]  <= de_to_ex;
        if (mem_allowin) valid[ST_MEM] <= ex_to_mem;
        valid[ST_WB] <= mem_to_wb;
        // The count runs down independently of MEM back-pressure.
        if (ex_ce && bus.de_is_mdu) begin
          cnt <= CNT_LOAD;
        end else if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (no forwarding / MDU_LAT=4 and
// forwarding / MDU_LAT=1) share one stimulus and are both tracked by a
// stage-occupancy reference model every cycle.
module tb_pipeline_ctrl;
  import cpu_pipe_pkg::*;

  logic       clk;
  logic       resetn;
  logic [4:0] raddr1, raddr2, ex_dest, mem_dest, wb_dest;
  logic       de_uses_rs, de_uses_rt, de_is_br, de_is_mdu;
  logic       ex_wen, ex_is_load, mem_wen, mem_is_load;
  logic       dram_busy, wb_wen, exc_flush;

  pipeline_ctrl_if bus0 ();
  pipeline_ctrl_if bus1 ();

  pipeline_ctrl #(.FWD_EN(1'b0), .MDU_LAT(4)) dut0 (.clk(clk), .resetn(resetn), .bus(bus0));
  pipeline_ctrl #(.FWD_EN(1'b1), .MDU_LAT(1)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1));

  assign bus0.raddr1 = raddr1;           assign bus1.raddr1 = raddr1;
  assign bus0.raddr2 = raddr2;           assign bus1.raddr2 = raddr2;
  assign bus0.de_uses_rs = de_uses_rs;   assign bus1.de_uses_rs = de_uses_rs;
  assign bus0.de_uses_rt = de_uses_rt;   assign bus1.de_uses_rt = de_uses_rt;
  assign bus0.de_is_br = de_is_br;       assign bus1.de_is_br = de_is_br;
  assign bus0.de_is_mdu = de_is_mdu;     assign bus1.de_is_mdu = de_is_mdu;
  assign bus0.ex_wen = ex_wen;           assign bus1.ex_wen = ex_wen;
  assign bus0.ex_dest = ex_dest;         assign bus1.ex_dest = ex_dest;
  assign bus0.ex_is_load = ex_is_load;   assign bus1.ex_is_load = ex_is_load;
  assign bus0.mem_wen = mem_wen;         assign bus1.mem_wen = mem_wen;
  assign bus0.mem_dest = mem_dest;       assign bus1.mem_dest = mem_dest;
  assign bus0.mem_is_load = mem_is_load; assign bus1.mem_is_load = mem_is_load;
  assign bus0.dram_busy = dram_busy;     assign bus1.dram_busy = dram_busy;
  assign bus0.wb_wen = wb_wen;           assign bus1.wb_wen = wb_wen;
  assign bus0.wb_dest = wb_dest;         assign bus1.wb_dest = wb_dest;
  assign bus0.exc_flush = exc_flush;     assign bus1.exc_flush = exc_flush;

  // Bit order: fe,de,ex,mem,wb valids, pc_we, de/ex/mem/wb_ce, de_stall, ex_busy
  logic [11:0] out0, out1;
  assign out0 = {bus0.fe_valid, bus0.de_valid, bus0.ex_valid, bus0.mem_valid, bus0.wb_valid,
                 bus0.pc_we, bus0.de_ce, bus0.ex_ce, bus0.mem_ce, bus0.wb_ce,
                 bus0.de_stall, bus0.ex_busy};
  assign out1 = {bus1.fe_valid, bus1.de_valid, bus1.ex_valid, bus1.mem_valid, bus1.wb_valid,
                 bus1.pc_we, bus1.de_ce, bus1.ex_ce, bus1.mem_ce, bus1.wb_ce,
                 bus1.de_stall, bus1.ex_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: occupancy per stage (bit 0 = FE ... bit 4 = WB) and
  // remaining MDU cycles, one set per instance.
  logic [4:0] mv [2];
  int         mcnt [2];
  int         lat [2];

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic src_haz(input int f, input logic [4:0] r, input logic used);
    logic hit [3];
    if (!used || r == 5'd0) return 1'b0;
    hit[0] = mv[f][2] && ex_wen  && ex_dest  == r;
    hit[1] = mv[f][3] && mem_wen && mem_dest == r;
    hit[2] = mv[f][4] && wb_wen  && wb_dest  == r;
    if (f == 0) return hit[0] || hit[1] || hit[2];
    return (hit[0] && (ex_is_load || de_is_br)) || (hit[1] && mem_is_load && dram_busy);
  endfunction

  function automatic void calc(input int f, output logic [11:0] o,
                               output logic [4:0] nv, output int ncnt);
    logic [4:0] v, rdy, allow, ce;
    logic       stall;
    v     = mv[f];
    stall = v[1] && (src_haz(f, raddr1, de_uses_rs) || src_haz(f, raddr2, de_uses_rt));
    rdy    = 5'b11111;
    rdy[1] = !stall;
    rdy[2] = (mcnt[f] == 0);
    rdy[3] = !dram_busy;
    allow    = '0;
    allow[4] = 1'b1;
    for (int s = 3; s >= 0; s--) allow[s] = !v[s] || (rdy[s] && allow[s+1]);
    ce = '0;
    for (int s = 1; s < 5; s++) ce[s] = allow[s] && v[s-1] && rdy[s-1];
    o = {v[0], v[1], v[2], v[3], v[4], (v[0] && allow[1]) || exc_flush,
         ce[1], ce[2], ce[3], ce[4], stall, v[2] && mcnt[f] != 0};
    if (exc_flush) begin
      nv   = 5'b00001;
      ncnt = 0;
    end else begin
      nv    = v;
      nv[0] = 1'b1;
      for (int s = 1; s < 5; s++) if (allow[s]) nv[s] = v[s-1] && rdy[s-1];
      if (ce[2] && de_is_mdu) ncnt = lat[f] - 1;
      else                    ncnt = (mcnt[f] > 0) ? mcnt[f] - 1 : 0;
    end
  endfunction

  task automatic step();
    logic [11:0] o0, o1;
    logic [4:0]  nv0, nv1;
    int          nc0, nc1;
    #1;
    calc(0, o0, nv0, nc0);
    calc(1, o1, nv1, nc1);
    chk("model_fwd0", out0, o0);
    chk("model_fwd1", out1, o1);
    @(posedge clk);
    if (resetn) begin
      mv[0] = nv0; mcnt[0] = nc0;
      mv[1] = nv1; mcnt[1] = nc1;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    raddr1 = '0; raddr2 = '0; ex_dest = '0; mem_dest = '0; wb_dest = '0;
    de_uses_rs = 0; de_uses_rt = 0; de_is_br = 0; de_is_mdu = 0;
    ex_wen = 0; ex_is_load = 0; mem_wen = 0; mem_is_load = 0;
    dram_busy = 0; wb_wen = 0; exc_flush = 0;
  endtask

  task automatic model_reset();
    mv[0] = '0; mv[1] = '0; mcnt[0] = 0; mcnt[1] = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    chk("reset_fwd0", out0, 12'b0);
    chk("reset_fwd1", out1, 12'b0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic fill();
    repeat (6) step();
  endtask

  typedef struct {
    logic [4:0]  r1;
    logic        use_rs;
    logic        ew;
    logic [4:0]  ed;
    logic        el;
    logic        mw;
    logic [4:0]  md;
    logic        ml;
    logic        ww;
    logic [4:0]  wd;
    logic [11:0] exp;
  } vec_t;

  function automatic vec_t mk(int r1, int u, int ew, int ed, int el, int mw, int md,
                              int ml, int ww, int wd, logic [11:0] e);
    vec_t t;
    t.r1 = 5'(r1); t.use_rs = 1'(u);
    t.ew = 1'(ew); t.ed = 5'(ed); t.el = 1'(el);
    t.mw = 1'(mw); t.md = 5'(md); t.ml = 1'(ml);
    t.ww = 1'(ww); t.wd = 5'(wd); t.exp = e;
    return t;
  endfunction

  vec_t tbl [10];
  logic exp_busy [4];
  logic exp_pcwe [4];
  logic exp_memv [4];

  initial begin
    lat[0] = 4;
    lat[1] = 1;
    clear_inputs();
    resetn = 1'b0;
    model_reset();

    // Fill from reset, then lw $2 flowing EX->MEM->WB against a DE reader (no forwarding).
    tbl[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b000000000000);
    tbl[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b100001100000);
    tbl[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b110001110000);
    tbl[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b111001111000);
    tbl[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b111101111100);
    tbl[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b111111111100);
    tbl[6] = mk(2, 1, 1, 2, 1, 0, 0, 0, 0, 0, 12'b111110001110);
    tbl[7] = mk(2, 1, 0, 0, 0, 1, 2, 1, 0, 0, 12'b110110000110);
    tbl[8] = mk(2, 1, 0, 0, 0, 0, 0, 0, 1, 2, 12'b110010000010);
    tbl[9] = mk(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 12'b110001110000);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      raddr1 = tbl[i].r1; de_uses_rs = tbl[i].use_rs;
      ex_wen = tbl[i].ew; ex_dest = tbl[i].ed; ex_is_load = tbl[i].el;
      mem_wen = tbl[i].mw; mem_dest = tbl[i].md; mem_is_load = tbl[i].ml;
      wb_wen = tbl[i].ww; wb_dest = tbl[i].wd;
      #1;
      chk($sformatf("tbl%0d", i), out0, tbl[i].exp);
      step();
    end

    // Forwarding: lw in EX gives exactly one bubble.
    do_reset();
    fill();
    raddr1 = 5'd2; de_uses_rs = 1; ex_wen = 1; ex_dest = 5'd2; ex_is_load = 1;
    #1; chk("fwd_lw_stall", 12'(out1[1]), 12'd1);
    step();
    ex_wen = 0; ex_is_load = 0; mem_wen = 1; mem_dest = 5'd2; mem_is_load = 1;
    #1; chk("fwd_lw_release", 12'(out1[1]), 12'd0);
    chk("fwd_lw_bubble", 12'(out1[9]), 12'd0);
    chk("fwd_lw_pcwe", 12'(out1[6]), 12'd1);
    step();
    // addu $2 in EX feeding a branch still stalls; feeding an ALU op does not.
    clear_inputs();
    raddr1 = 5'd2; de_uses_rs = 1; ex_wen = 1; ex_dest = 5'd2; de_is_br = 1;
    #1; chk("fwd_br_stall", 12'(out1[1]), 12'd1);
    step();
    de_is_br = 0;
    #1; chk("fwd_alu_nostall", 12'(out1[1]), 12'd0);
    step();
    // rt side, register $0 never hazards.
    clear_inputs();
    raddr2 = 5'd0; de_uses_rt = 1; ex_wen = 1; ex_dest = 5'd0; ex_is_load = 1;
    #1; chk("zero_reg_fwd0", 12'(out0[1]), 12'd0);
    step();
    clear_inputs();

    // MDU: dut0 holds EX for 4 cycles, dut1 (latency 1) never stalls.
    do_reset();
    fill();
    de_is_mdu = 1;
    step();
    de_is_mdu = 0;
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_pcwe = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_memv = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mdu_busy%0d", i), 12'(out0[0]), 12'(exp_busy[i]));
      chk($sformatf("mdu_pcwe%0d", i), 12'(out0[6]), 12'(exp_pcwe[i]));
      chk($sformatf("mdu_memv%0d", i), 12'(out0[8]), 12'(exp_memv[i]));
      if (i == 0) begin
        chk("mdu_lat1_busy", 12'(out1[0]), 12'd0);
        chk("mdu_lat1_pcwe", 12'(out1[6]), 12'd1);
      end
      step();
    end

    // Data RAM busy for two cycles with MEM valid.
    do_reset();
    fill();
    for (int i = 0; i < 3; i++) begin
      dram_busy = (i < 2);
      #1;
      chk($sformatf("dram_wbv%0d", i), 12'(out0[7]), (i == 0) ? 12'd1 : 12'd0);
      chk($sformatf("dram_pcwe%0d", i), 12'(out0[6]), (i == 2) ? 12'd1 : 12'd0);
      chk($sformatf("dram_memce%0d", i), 12'(out0[3]), (i == 2) ? 12'd1 : 12'd0);
      step();
    end
    clear_inputs();

    // Flush during MDU countdown plus dram_busy.
    do_reset();
    fill();
    de_is_mdu = 1;
    step();
    de_is_mdu = 0; dram_busy = 1; exc_flush = 1;
    #1; chk("flush_pcwe", 12'(out0[6]), 12'd1);
    step();
    clear_inputs();
    #1;
    chk("flush_valids0", 12'(out0[11:7]), 12'b10000);
    chk("flush_valids1", 12'(out1[11:7]), 12'b10000);
    chk("flush_cnt", 12'(dut0.cnt), 12'd0);
    chk("flush_busy", 12'(out0[0]), 12'd0);
    step();

    // Asynchronous reset in the middle of a stall.
    do_reset();
    fill();
    raddr1 = 5'd3; de_uses_rs = 1; ex_wen = 1; ex_dest = 5'd3; ex_is_load = 1;
    #1; chk("midstall_stall", 12'(out0[1]), 12'd1);
    #1; resetn = 1'b0;
    #1;
    chk("midstall_rst0", out0, 12'b0);
    chk("midstall_rst1", out1, 12'b0);
    model_reset();
    @(negedge clk);
    clear_inputs();
    resetn = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if (!resetn) begin
        resetn = 1'b1;
      end else if ($urandom_range(0, 99) == 0) begin
        resetn = 1'b0;
        model_reset();
      end
      raddr1      = 5'($urandom_range(0, 3));
      raddr2      = 5'($urandom_range(0, 3));
      ex_dest     = 5'($urandom_range(0, 3));
      mem_dest    = 5'($urandom_range(0, 3));
      wb_dest     = 5'($urandom_range(0, 3));
      de_uses_rs  = 1'($urandom_range(0, 1));
      de_uses_rt  = 1'($urandom_range(0, 1));
      de_is_br    = ($urandom_range(0, 3) == 0);
      de_is_mdu   = ($urandom_range(0, 5) == 0);
      ex_wen      = 1'($urandom_range(0, 1));
      ex_is_load  = 1'($urandom_range(0, 1));
      mem_wen     = 1'($urandom_range(0, 1));
      mem_is_load = 1'($urandom_range(0, 1));
      wb_wen      = 1'($urandom_range(0, 1));
      dram_busy   = ($urandom_range(0, 3) == 0);
      exc_flush   = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
